// File: rtl/mmio_led_ctrl_if.sv
// CPU data-bus slice seen by the LED controller: write strobe, address, data and readback.
interface mmio_led_ctrl_if;
    logic        we;
    logic [31:0] daddr;
    logic [31:0] din;
    logic        hit;
    logic [31:0] dout;

    modport master (
        output we,
        output daddr,
        output din,
        input  hit,
        input  dout
    );

    modport slave (
        input  we,
        input  daddr,
        input  din,
        output hit,
        output dout
    );
endinterface

// File: rtl/mmio_led_ctrl.sv
// Memory-mapped LED controller: per-channel off/on/blink/PWM modes behind a 64 KiB bus window,
// with a shared blink prescaler and a shared free-running PWM counter.
module mmio_led_ctrl #(
    parameter int unsigned NUM_LEDS  = 4,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned PWM_W     = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    mmio_led_ctrl_if.slave      bus,
    output logic [NUM_LEDS-1:0] led
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [PWM_W-1:0] PwmOne = PWM_W'(1);

    logic [13:0]        off;
    logic               wr_en;
    logic               wr_prescale;
    logic [CNT_W-1:0]   prescale_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               blink_phase_q;
    logic [PWM_W-1:0]   pwm_cnt_q;
    logic [1:0]         mode_q [NUM_LEDS];
    logic [PWM_W-1:0]   duty_q [NUM_LEDS];
    logic [31:0]        rdata;
    logic [31:0]        dout_q;
    logic [NUM_LEDS-1:0] led_d;
    logic [NUM_LEDS-1:0] led_q;
    logic               unused_bits;

    assign bus.hit     = (bus.daddr[31:16] == BASE_ADDR[31:16]);
    assign off         = bus.daddr[15:2];
    assign wr_en       = bus.we && bus.hit;
    assign wr_prescale = wr_en && (off == '0);
    assign unused_bits = ^{bus.din, bus.daddr[1:0]};

    always_comb begin
        rdata = '0;
        if (off == '0) begin
            rdata[CNT_W-1:0] = prescale_q;
        end
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (off == 14'(4 + i)) begin
                rdata[1:0]       = mode_q[i];
                rdata[8 +: PWM_W] = duty_q[i];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_q[i] <= '0;
                duty_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (off == 14'(4 + i)) begin
                    mode_q[i] <= bus.din[1:0];
                    duty_q[i] <= bus.din[8 +: PWM_W];
                end
            end
        end
    end

    // A PRESCALE write restarts the count but never toggles the phase on that edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            prescale_q    <= '0;
            cnt_q         <= '0;
            blink_phase_q <= 1'b0;
        end else if (wr_prescale) begin
            prescale_q <= bus.din[CNT_W-1:0];
            cnt_q      <= '0;
        end else if (prescale_q == '0) begin
            cnt_q <= '0;
        end else if (cnt_q == prescale_q - CntOne) begin
            cnt_q         <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            cnt_q <= cnt_q + CntOne;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PwmOne;
        end
    end

    // Readback captures the pre-write register value when read and write share an edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dout_q <= '0;
        end else if (bus.hit) begin
            dout_q <= rdata;
        end
    end

    assign bus.dout = dout_q;

    always_comb begin
        led_d = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            unique case (mode_q[i])
                2'b00:   led_d[i] = 1'b0;
                2'b01:   led_d[i] = 1'b1;
                2'b10:   led_d[i] = blink_phase_q;
                default: led_d[i] = (pwm_cnt_q < duty_q[i]);
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_mmio_led_ctrl.sv
// Self-checking bench for mmio_led_ctrl: scoreboarded bus readback plus LED timing checks.
module tb_mmio_led_ctrl;

    localparam int unsigned NumLeds = 4;
    localparam logic [31:0] IdleAddr = 32'h0000_0000;
    localparam logic [31:0] AddrPre  = 32'h8000_0000;
    localparam logic [31:0] AddrCh0  = 32'h8000_0010;
    localparam logic [31:0] AddrCh1  = 32'h8000_0014;
    localparam logic [31:0] AddrCh2  = 32'h8000_0018;
    localparam logic [31:0] AddrCh3  = 32'h8000_001C;

    typedef struct {
        string       tag;
        logic [31:0] data;
    } exp_t;

    logic               sys_clk;
    logic               sys_rst_n;
    logic [NumLeds-1:0] led;
    exp_t               sb_q[$];
    int                 n_checks;
    int                 n_fails;

    mmio_led_ctrl_if bus_if ();

    mmio_led_ctrl #(
        .NUM_LEDS  (NumLeds),
        .BASE_ADDR (32'h8000_0000),
        .CNT_W     (24),
        .PWM_W     (8)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus_if),
        .led       (led)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic sb_compare();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, bus_if.dout, e.data);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus_if.we    = 1'b1;
        bus_if.daddr = addr;
        bus_if.din   = data;
        tick();
        bus_if.we    = 1'b0;
        bus_if.daddr = IdleAddr;
    endtask

    task automatic bus_read(input logic [31:0] addr, input string tag, input logic [31:0] exp);
        bus_if.we    = 1'b0;
        bus_if.daddr = addr;
        sb_q.push_back('{tag, exp});
        tick();
        bus_if.daddr = IdleAddr;
        sb_compare();
    endtask

    // Counts cycles in which led[idx] is high over a window of n consecutive samples.
    task automatic count_high(input int idx, input int n, output int highs);
        highs = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (led[idx]) highs++;
        end
    endtask

    initial begin
        int   toggles;
        int   last_t;
        int   highs;
        logic prev;

        n_checks = 0;
        n_fails  = 0;

        // Reset with undriven bus.
        sys_rst_n    = 1'b0;
        bus_if.we    = 1'bx;
        bus_if.daddr = 'x;
        bus_if.din   = 'x;
        #12;
        check_eq("rst_led", 32'(led), 32'd0);
        check_eq("rst_dout", bus_if.dout, 32'd0);
        bus_if.daddr = 32'h8000_0010;
        #1;
        check_eq("hit_in_window", 32'(bus_if.hit), 32'd1);
        bus_if.daddr = 32'h8001_0000;
        #1;
        check_eq("hit_out_window", 32'(bus_if.hit), 32'd0);
        bus_if.we    = 1'b0;
        bus_if.daddr = IdleAddr;
        bus_if.din   = '0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();

        // Static on/off.
        bus_write(AddrCh0, 32'h1);
        check_eq("on_not_yet", 32'(led), 32'd0);
        tick();
        check_eq("on_visible", 32'(led), 32'h1);
        tick();
        check_eq("on_held", 32'(led), 32'h1);
        bus_write(AddrCh0, 32'h0);
        check_eq("off_not_yet", 32'(led), 32'h1);
        tick();
        check_eq("off_visible", 32'(led), 32'd0);

        // Blink with PRESCALE=4: toggle every 4 cycles.
        bus_write(AddrPre, 32'd4);
        bus_write(AddrCh1, 32'h2);
        tick();
        prev    = led[1];
        toggles = 0;
        last_t  = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (led[1] !== prev) begin
                toggles++;
                if (last_t >= 0) check_eq("blink_interval", 32'(k - last_t), 32'd4);
                last_t = k;
                prev   = led[1];
            end
        end
        check_eq("blink_toggles", 32'(toggles), 32'd10);

        // PRESCALE=0 freezes the phase.
        bus_write(AddrPre, 32'd0);
        tick();
        tick();
        prev    = led[1];
        toggles = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (led[1] !== prev) toggles++;
        end
        check_eq("blink_frozen", 32'(toggles), 32'd0);

        // PWM duty windows.
        bus_write(AddrCh2, 32'h0000_4003);
        tick();
        count_high(2, 256, highs);
        check_eq("pwm_duty64", 32'(highs), 32'd64);
        bus_write(AddrCh2, 32'h0000_0003);
        tick();
        count_high(2, 256, highs);
        check_eq("pwm_duty0", 32'(highs), 32'd0);
        bus_write(AddrCh2, 32'h0000_FF03);
        tick();
        count_high(2, 256, highs);
        check_eq("pwm_duty255", 32'(highs), 32'd255);

        // Readback.
        bus_write(AddrCh3, 32'hFFFF_FFFF);
        bus_read(AddrCh3, "rd_ch3", 32'h0000_FF03);
        bus_read(32'h8000_001F, "rd_ch3_unaligned", 32'h0000_FF03);
        bus_write(AddrPre, 32'hFF12_3456);
        bus_read(AddrPre, "rd_prescale", 32'h0012_3456);
        bus_write(32'h8000_0050, 32'hFFFF_FFFF);
        bus_read(32'h8000_0050, "rd_unmapped", 32'h0000_0000);
        bus_read(AddrCh1, "rd_ch1", 32'h0000_0002);
        bus_read(AddrCh2, "rd_ch2", 32'h0000_FF03);

        // Read and write of the same offset on one edge returns the old value.
        sb_q.push_back('{"rw_same_old", 32'h0000_0000});
        bus_write(AddrCh0, 32'h0000_1201);
        sb_compare();
        bus_read(AddrCh0, "rd_ch0_new", 32'h0000_1201);

        // With hit low, dout holds.
        bus_if.daddr = 32'h1234_0000;
        sb_q.push_back('{"dout_hold", 32'h0000_1201});
        tick();
        sb_compare();
        bus_if.daddr = IdleAddr;

        // Async reset during blink.
        bus_write(AddrPre, 32'd4);
        for (int k = 0; k < 6; k++) tick();
        check_eq("pre_rst_led0", 32'(led[0]), 32'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_eq("async_rst_led", 32'(led), 32'd0);
        check_eq("async_rst_dout", bus_if.dout, 32'd0);
        #2;
        sys_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("post_rst_led", 32'(led), 32'd0);
        end
        bus_read(AddrCh1, "post_rst_ch1", 32'h0000_0000);
        bus_read(AddrPre, "post_rst_prescale", 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
